// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// nibble_serial_addsub_ctrl_pkg: shared types and constants for the nibble-serial add/sub sequencer
// Contents: state_e (IDLE/RUN/DONE), NIBBLE_W slice width, idx_w() index-counter width helper.
package nibble_serial_addsub_ctrl_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
  // Width of the nibble index counter; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/addsub_nibble_slice.sv
// addsub_nibble_slice: combinational 4-bit ripple adder-subtractor slice
// Ports: a, b   - operand nibbles (b is inverted when sel=1)
//        sel    - 1 selects subtract (b XOR 1111)
//        cin    - carry into bit 0
//        sum    - 4-bit sum, cout - carry out of bit 3, c3 - carry into bit 3
module addsub_nibble_slice
  import nibble_serial_addsub_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                sel,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                c3
);
  logic [NIBBLE_W:0]   c;
  logic [NIBBLE_W-1:0] bx;
  always_comb begin
    bx   = b ^ {NIBBLE_W{sel}};
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end
  assign cout = c[NIBBLE_W];
  assign c3   = c[NIBBLE_W-1];
endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// nibble_serial_addsub_ctrl: wide add/subtract computed one nibble per clock through a shared slice
// Ports: clk, rst (async active-high)
//        start_valid/start_ready - request handshake; a, b, sel latched on accept
//        res_valid/res_ready     - result handshake; result, carry_out held until next op
//        busy                    - high while RUN or DONE
//        zero, ovf               - present only when ADDSUB_FLAGS_EN is defined
// Optional feature macro: ADDSUB_FLAGS_EN
module nibble_serial_addsub_ctrl
  import nibble_serial_addsub_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_valid,
  output logic                        start_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        sel,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                        carry_out,
`ifdef ADDSUB_FLAGS_EN
  output logic                        zero,
  output logic                        ovf,
`endif
  output logic                        busy
);
  localparam int IW = idx_w(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
  state_e state_q, state_d;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic sel_q, sel_d, cy_q, cy_d, co_q, co_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NIBBLE_W-1:0] sum;
  logic cout, c3;
`ifdef ADDSUB_FLAGS_EN
  logic zero_q, zero_d, ovf_q, ovf_d;
  assign zero = zero_q;
  assign ovf  = ovf_q;
`else
  logic unused_c3;
  assign unused_c3 = c3;
`endif
  addsub_nibble_slice u_slice (
    .a   (a_q[idx_q]),
    .b   (b_q[idx_q]),
    .sel (sel_q),
    .cin (cy_q),
    .sum (sum),
    .cout(cout),
    .c3  (c3)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    cy_d    = cy_q;
    co_d    = co_q;
    idx_d   = idx_q;
    res_d   = res_q;
`ifdef ADDSUB_FLAGS_EN
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`endif
    if (state_q == IDLE && start_valid) begin
      state_d = RUN;
      a_d     = a;
      b_d     = b;
      sel_d   = sel;
      cy_d    = sel;  // initial carry of 1 completes A + ~B + 1
      idx_d   = '0;
    end else if (state_q == RUN) begin
      res_d[idx_q] = sum;
      cy_d         = cout;
      idx_d        = idx_q + 1'b1;
      if (idx_q == LAST) begin
        state_d = DONE;
        co_d    = cout;
        idx_d   = '0;
`ifdef ADDSUB_FLAGS_EN
        zero_d  = (res_d == '0);
        ovf_d   = c3 ^ cout;
`endif
      end
    end else if (state_q == DONE && res_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 1'b0;
      cy_q    <= 1'b0;
      co_q    <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
`ifdef ADDSUB_FLAGS_EN
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      cy_q    <= cy_d;
      co_q    <= co_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
`ifdef ADDSUB_FLAGS_EN
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`endif
    end
  end
  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign result      = res_q;
  assign carry_out   = co_q;
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// tb_nibble_serial_addsub_ctrl: directed and randomized checks of the nibble-serial add/sub sequencer
module tb_nibble_serial_addsub_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;
  logic clk, rst, start_valid, start_ready, sel, res_valid, res_ready, carry_out, busy;
  logic [W-1:0] a, b, result;
`ifdef ADDSUB_FLAGS_EN
  logic zero, ovf;
`endif
  int checks, failures, cyc;
  nibble_serial_addsub_ctrl #(.NIBBLES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a          (a),
    .b          (b),
    .sel        (sel),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .result     (result),
    .carry_out  (carry_out),
`ifdef ADDSUB_FLAGS_EN
    .zero       (zero),
    .ovf        (ovf),
`endif
    .busy       (busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Reference: plain unsigned arithmetic; carry is the natural carry for add, A>=B for subtract.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    longint sx, sy, r;
    logic c;
    sx = longint'(x);
    sy = longint'(y);
    r  = s ? sx - sy : sx + sy;
    c  = s ? (sx >= sy) : (r >= (longint'(1) << W));
    return {c, W'(r & ((longint'(1) << W) - 1))};
  endfunction
`ifdef ADDSUB_FLAGS_EN
  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    longint sx, sy, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = s ? sx - sy : sx + sy;
    return (r > (longint'(1) << (W-1)) - 1) || (r < -(longint'(1) << (W-1)));
  endfunction
`endif
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os, input int hold);
    logic [W:0] e;
    int n;
    e = model(oa, ob, os);
    n = 0;
    while (!start_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("ready_before_op", start_ready, 1);
    a = oa; b = ob; sel = os; start_valid = 1'b1; res_ready = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0; a = W'($urandom); b = W'($urandom); sel = 1'($urandom);
    chk("busy_after_accept", {busy, start_ready}, 2'b10);
    n = 0;
    while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("latency", n, N);
    chk("result", result, e[W-1:0]);
    chk("carry_out", carry_out, e[W]);
`ifdef ADDSUB_FLAGS_EN
    chk("zero", zero, e[W-1:0] == '0);
    chk("ovf", ovf, model_ovf(oa, ob, os));
`endif
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk("hold_state", {res_valid, start_ready, busy}, 3'b101);
      chk("hold_result", {carry_out, result}, e);
    end
    start_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("back_to_idle", {start_ready, res_valid, busy}, 3'b100);
    chk("result_kept", {carry_out, result}, e);
  endtask
  initial begin
    logic [W-1:0] oa, ob;
    logic os;
    logic [W:0] e;
    int n, last;
    checks = 0; failures = 0;
    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {start_ready, res_valid, busy, carry_out}, 4'b1000);
    chk("reset_result", result, 0);
    @(negedge clk); rst = 1'b0;
    run_op(16'h1234, 16'h0FCD, 1'b0, 5);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'h5000, 16'h0001, 1'b1, 0);
    run_op(16'h0003, 16'h0005, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 1'b1, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h1234, 16'h1234, 1'b1, 2);
    // Abort mid-RUN with an asynchronous reset.
    a = 16'hFFFF; b = 16'hFFFF; sel = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1; #1;
    chk("async_reset_state", {start_ready, res_valid, busy, carry_out}, 4'b1000);
    chk("async_reset_result", result, 0);
    @(negedge clk); rst = 1'b0;
    run_op(16'h0001, 16'h0001, 1'b0, 0);
    // Back-to-back with continuous valid/ready.
    res_ready = 1'b1; start_valid = 1'b1;
    a = W'($urandom); b = W'($urandom); sel = 1'($urandom);
    last = 0;
    for (int i = 0; i < 200; i++) begin
      oa = a; ob = b; os = sel;
      e = model(oa, ob, os);
      n = 0;
      while (!start_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("b2b_ready", start_ready, 1);
      @(posedge clk); #1;
      if (i > 0) chk("b2b_spacing", cyc - last, N + 2);
      last = cyc;
      a = W'($urandom); b = W'($urandom); sel = 1'($urandom);
      n = 0;
      while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("b2b_result", {carry_out, result}, e);
    end
    start_valid = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nibble_serial_addsub_ctrl.md
Name: nibble_serial_addsub_ctrl

Overview:
Sequencer that performs a wide add/subtract (4*NIBBLES bits) by time-multiplexing one 4-bit ripple adder-subtractor, one nibble per clock, LSB first. It chains the carry through a register between nibbles. It sits between a requester using a valid/ready handshake and the shared nibble datapath, and returns the full result plus the final carry/no-borrow flag.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation (operand width = 4*NIBBLES); legal range 2..16.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start_valid  input  1  request present
start_ready  output  1  controller can accept a request
a  input  4*NIBBLES  operand A
b  input  4*NIBBLES  operand B
sel  input  1  0 = A+B, 1 = A-B (two's complement)
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
result  output  4*NIBBLES  sum/difference, modulo 2^(4*NIBBLES)
carry_out  output  1  carry out of MSB nibble; for subtract, 1 = no borrow (A>=B unsigned)
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, any state): state=IDLE, start_ready=1, res_valid=0, busy=0, result=0, carry_out=0, nibble index=0, carry register=0.
- States: IDLE, RUN, DONE.
- IDLE: start_ready=1. If start_valid, on the edge latch a, b, sel into operand registers; carry register <= sel; index <= 0; go RUN. Inputs are not sampled at any other time.
- RUN: start_ready=0. Datapath inputs: A nibble[index]; B nibble[index] XOR {4{sel_q}}; carry-in = carry register. Each edge: result nibble[index] <= sum; carry register <= nibble carry-out; index++. On the edge where index==NIBBLES-1: carry_out <= nibble carry-out; go DONE.
- DONE: res_valid=1, result/carry_out stable. On res_valid&&res_ready, go IDLE; result/carry_out hold their values until the next operation overwrites them.
- Latency: res_valid rises exactly NIBBLES cycles after the accept edge. Minimum initiation interval is NIBBLES+2 cycles, because start_ready is asserted only in IDLE; there is no overlap.
- start_valid while not IDLE is ignored (not queued). Requester must hold a/b/sel only until the accept edge.
- res_ready high outside DONE has no effect. res_ready low holds DONE indefinitely.
- Arithmetic is unsigned modulo 2^(4*NIBBLES). Subtract equals A + ~B + 1 via the initial carry = sel.
- Reset asserted mid-RUN aborts the operation. No partial result is flagged valid.

Optional Feature:
ADDSUB_FLAGS_EN
- Defined: adds outputs zero (1 bit, result==0) and ovf (1 bit, signed two's-complement overflow = carry-in XOR carry-out of the MSB nibble's top bit). Both are registered on the final RUN edge, valid with res_valid, and reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: state enum (IDLE/RUN/DONE, 2-bit encoding), NIBBLE_W=4 constant, and an index-width function computing clog2(NIBBLES).
- One sub-module, addsub_nibble_slice: purely combinational 4-bit ripple adder with B XOR sel and carry-in. It is instantiated once and outputs sum[3:0], cout, and (for the flag feature) the carry into bit 3.
- The controller holds the FSM, operand/result registers, and carry/index counters.

Test Plan:
- NIBBLES=4, sel=0, a=0x1234, b=0x0FCD -> res_valid at accept+4 cycles, result=0x2201, carry_out=0.
- sel=0, a=0xFFFF, b=0x0001 -> result=0x0000, carry_out=1 (full carry ripple across all nibbles); with flags: zero=1, ovf=0.
- sel=1, a=0x5000, b=0x0001 -> result=0x4FFF, carry_out=1; then sel=1, a=0x0003, b=0x0005 -> result=0xFFFE, carry_out=0; with flags, a=0x8000, b=0x0001 -> ovf=1.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> result stable, start_ready=0, start_valid pulses ignored; on res_ready=1, IDLE next cycle and start_ready=1.
- Assert rst asynchronously (mid-cycle) at the 2nd RUN cycle -> all outputs at reset values immediately. A new request afterward (0x0001+0x0001) yields 0x0002 with no stale carry.
- Back-to-back: keep start_valid=1 and res_ready=1 with random operands for 200 ops -> every result matches a reference model; spacing between accepts = NIBBLES+2 cycles.
